// File: rtl/irq_ctrl.sv
// Interrupt controller beside the 5-stage pipeline: synchronises async lines, latches rising
// edges as pending, picks the lowest-index unmasked line, and nests via a return stack.
// Entry and eret each produce a one-cycle redirect pulse with the target address.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned NEST_DEPTH = 2,
  parameter logic [31:0] VEC_BASE   = 32'h00003024,
  parameter logic [31:0] VEC_STRIDE = 32'h000000a4,
  localparam int unsigned ID_W      = $clog2(NUM_IRQ),
  localparam int unsigned LVL_W     = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               eret,
  input  logic [31:0]        ret_pc,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               int_req,
  output logic [31:0]        int_addr,
  output logic               eret_req,
  output logic [31:0]        eret_addr,
  output logic               cur_valid,
  output logic [ID_W-1:0]    cur_irq,
  output logic [LVL_W-1:0]   level,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  // Stack is sized to the full level index range so the level counter indexes it exactly.
  localparam int unsigned      StkN   = 1 << LVL_W;
  localparam logic [LVL_W-1:0] MaxLvl = LVL_W'(NEST_DEPTH);

  typedef enum logic [1:0] {StRun, StTake, StRet, StHold} state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQ-1:0] rise, elig, pending_d;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               take, ret;
  logic [ID_W-1:0]    stk_id [StkN];
  logic [31:0]        stk_pc [StkN];

  assign cur_valid = (level != '0);

  // Edge detect, priority pick and take/return decisions.
  always_comb begin
    rise    = s2_q & ~s3_q;
    elig    = pending & ~mask;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && !win_vld) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
    ret  = (state_q == StRun) && eret && (level != '0);
    // eret has priority over a simultaneous take; the interrupt is retried after HOLD.
    take = (state_q == StRun) && !eret && win_vld &&
           ((level == '0) || ((level < MaxLvl) && (win_id < cur_irq)));
    pending_d = pending;
    if (take) pending_d[win_id] = 1'b0;
    // A new edge on the line being taken re-pends it.
    pending_d = pending_d | rise;
  end

  // Synchronisers, pending latch and mask register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      s1_q    <= irq;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pending <= pending_d;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Sequencing FSM with registered redirect pulses, nesting level and return stack.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StRun;
      int_req   <= 1'b0;
      int_addr  <= '0;
      eret_req  <= 1'b0;
      eret_addr <= '0;
      level     <= '0;
      cur_irq   <= '0;
      for (int i = 0; i < StkN; i++) begin
        stk_id[i] <= '0;
        stk_pc[i] <= '0;
      end
    end else begin
      int_req  <= 1'b0;
      eret_req <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (ret) begin
            state_q   <= StRet;
            eret_req  <= 1'b1;
            eret_addr <= stk_pc[level - LVL_W'(1)];
            level     <= level - LVL_W'(1);
            cur_irq   <= (level > LVL_W'(1)) ? stk_id[level - LVL_W'(2)] : '0;
          end else if (take) begin
            state_q       <= StTake;
            int_req       <= 1'b1;
            int_addr      <= VEC_BASE + 32'(win_id) * VEC_STRIDE;
            stk_id[level] <= win_id;
            stk_pc[level] <= ret_pc;
            level         <= level + LVL_W'(1);
            cur_irq       <= win_id;
          end
        end
        StTake, StRet: state_q <= StHold;
        StHold:        state_q <= StRun;
        default:       state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected redirect pulses (kind, address,
// level, cur_irq, cycle); a negedge monitor pops and compares each pulse the DUT emits.
module tb_irq_ctrl;

  logic        clk, clr, eret, mask_we;
  logic [3:0]  irq, mask_wdata;
  logic [31:0] ret_pc;
  logic        int_req, eret_req, cur_valid;
  logic [31:0] int_addr, eret_addr;
  logic [1:0]  cur_irq, level;
  logic [3:0]  pending, mask;

  typedef struct {
    bit          is_eret;
    logic [31:0] addr;
    int          lvl;
    int          cur;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  irq_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .irq        (irq),
    .eret       (eret),
    .ret_pc     (ret_pc),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_req    (int_req),
    .int_addr   (int_addr),
    .eret_req   (eret_req),
    .eret_addr  (eret_addr),
    .cur_valid  (cur_valid),
    .cur_irq    (cur_irq),
    .level      (level),
    .pending    (pending),
    .mask       (mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit er, input logic [31:0] a, input int lvl, input int cur,
                      input int at);
    exp_t e;
    e.is_eret = er;
    e.addr    = a;
    e.lvl     = lvl;
    e.cur     = cur;
    e.at      = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input int line);
    irq[line] = 1'b1;
    @(negedge clk);
    irq[line] = 1'b0;
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
  endtask

  // Monitor: every redirect pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!clr && (int_req || eret_req)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: int_req=%0b eret_req=%0b, expected none (cycle %0d)",
                 int_req, eret_req, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, int_req, eret_req}, e.is_eret ? 32'd1 : 32'd2);
        chk("pulse_addr", e.is_eret ? eret_addr : int_addr, e.addr);
        chk("pulse_level", 32'(level), 32'(e.lvl));
        chk("pulse_cur_irq", 32'(cur_irq), 32'(e.cur));
        chk("pulse_cur_valid", 32'(cur_valid), (e.lvl != 0) ? 32'd1 : 32'd0);
        chk("pulse_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int c;
    clr        = 1'b1;
    irq        = '0;
    eret       = 1'b0;
    ret_pc     = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    tick(2);
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_eret_req", 32'(eret_req), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_int_addr", int_addr, 32'd0);
    clr = 1'b0;
    tick(2);

    // Single interrupt on line 2, then eret.
    c = cyc;
    ret_pc = 32'h0000_1000;
    push(0, 32'h0000_316c, 1, 2, c + 4);
    raise(2);
    tick(1);
    chk("single_pending_early", 32'(pending), 32'h0);
    tick(1);
    chk("single_pending", 32'(pending), 32'h4);
    tick(1);
    chk("single_pending_cleared", 32'(pending), 32'h0);
    tick(2);
    push(1, 32'h0000_1000, 0, 0, c + 7);
    eret_pulse();
    tick(3);

    // Lines 3 and 1 together: 1 first, 3 after eret + HOLD.
    c = cyc;
    ret_pc = 32'h0000_2000;
    push(0, 32'h0000_30c8, 1, 1, c + 4);
    irq = 4'b1010;
    tick(1);
    irq = '0;
    tick(3);
    chk("prio_pending_held", 32'(pending), 32'h8);
    tick(2);
    ret_pc = 32'h0000_2100;
    push(1, 32'h0000_2000, 0, 0, c + 7);
    push(0, 32'h0000_3210, 1, 3, c + 10);
    eret_pulse();
    tick(5);
    push(1, 32'h0000_2100, 0, 0, c + 13);
    eret_pulse();
    tick(3);

    // Nesting: 2, preempted by 0; 1 held at full depth, then preempts 2 after eret.
    c = cyc;
    ret_pc = 32'h0000_3000;
    push(0, 32'h0000_316c, 1, 2, c + 4);
    raise(2);
    tick(3);
    ret_pc = 32'h0000_3100;
    push(0, 32'h0000_3024, 2, 0, c + 8);
    raise(0);
    raise(1);
    tick(2);
    chk("nest_level", 32'(level), 32'd2);
    chk("nest_cur_irq", 32'(cur_irq), 32'd0);
    tick(4);
    chk("nest_full_held", 32'(pending), 32'h2);
    push(1, 32'h0000_3100, 1, 2, c + 13);
    push(0, 32'h0000_30c8, 2, 1, c + 16);
    eret_pulse();
    ret_pc = 32'h0000_3200;
    tick(5);
    push(1, 32'h0000_3200, 1, 2, c + 19);
    eret_pulse();
    tick(3);
    push(1, 32'h0000_3000, 0, 0, c + 23);
    eret_pulse();
    tick(3);

    // Mask line 0: stays pending, taken one cycle after unmask.
    c = cyc;
    mask_we    = 1'b1;
    mask_wdata = 4'b0001;
    tick(1);
    mask_we = 1'b0;
    chk("mask_written", 32'(mask), 32'h1);
    raise(0);
    tick(3);
    chk("mask_pending", 32'(pending), 32'h1);
    tick(3);
    chk("mask_still_pending", 32'(pending), 32'h1);
    chk("mask_level", 32'(level), 32'd0);
    ret_pc     = 32'h0000_5000;
    mask_we    = 1'b1;
    mask_wdata = 4'b0000;
    push(0, 32'h0000_3024, 1, 0, c + 10);
    tick(1);
    mask_we = 1'b0;
    tick(3);
    push(1, 32'h0000_5000, 0, 0, c + 13);
    eret_pulse();
    tick(3);

    // Idle eret is ignored; eret colliding with a take wins, take follows after HOLD.
    eret_pulse();
    chk("idle_eret_req", 32'(eret_req), 32'd0);
    tick(1);
    chk("idle_eret_level", 32'(level), 32'd0);
    tick(2);
    c = cyc;
    ret_pc = 32'h0000_6000;
    push(0, 32'h0000_3210, 1, 3, c + 4);
    raise(3);
    tick(5);
    raise(2);
    tick(2);
    ret_pc = 32'h0000_6100;
    push(1, 32'h0000_6000, 0, 0, c + 10);
    push(0, 32'h0000_316c, 1, 2, c + 13);
    eret_pulse();
    tick(5);
    push(1, 32'h0000_6100, 0, 0, c + 16);
    eret_pulse();
    tick(3);

    // Asynchronous reset in the middle of a TAKE cycle.
    c = cyc;
    ret_pc     = 32'h0000_7000;
    irq        = 4'b1010;
    mask_we    = 1'b1;
    mask_wdata = 4'b1000;
    push(0, 32'h0000_30c8, 1, 1, c + 4);
    tick(1);
    irq     = '0;
    mask_we = 1'b0;
    tick(3);
    chk("rst_mid_pending_before", 32'(pending), 32'h8);
    #1 clr = 1'b1;
    #1;
    chk("rst_mid_int_req", 32'(int_req), 32'd0);
    chk("rst_mid_level", 32'(level), 32'd0);
    chk("rst_mid_pending", 32'(pending), 32'd0);
    chk("rst_mid_mask", 32'(mask), 32'd0);
    chk("rst_mid_cur_valid", 32'(cur_valid), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    tick(4);
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
